gate_vector_seq: RTL
====================

GATE_VECTOR_SEQ -- requirements
Module: gate_vector_seq

Interface
REQ-001 Parameter DWELL_W, default 8, is the width of the per-vector dwell count.
REQ-002 Parameter ERR_W, default 8, is the width of the mismatch counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begins a sweep when sampled high in IDLE; ignored otherwise.
REQ-006 cont  input  1  continuous mode: sweep restarts automatically while high.
REQ-007 mode  input  2  expected gate function: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-008 dwell  input  DWELL_W  cycles each vector is held; 0 treated as 1.
REQ-009 a_out  output  1  registered stimulus to DUT input a.
REQ-010 b_out  output  1  registered stimulus to DUT input b.
REQ-011 c_in  input  1  DUT response, combinational function of a_out/b_out.
REQ-012 busy  output  1  high while vectors are being applied.
REQ-013 done  output  1  one-cycle pulse at end of each sweep.
REQ-014 pass  output  1  high when last completed sweep had zero mismatches.
REQ-015 err_cnt  output  ERR_W  mismatches since last start, saturating.
REQ-016 first_fail  output  3  {valid, vec_idx} of first mismatch since start; 000 if none.
REQ-017 vec_idx  output  2  index of vector currently applied.

Function
REQ-018 FSM states SHALL be IDLE, HOLD, DONE; encoding is free.
REQ-019 IDLE: start=1 -> latch mode, D=max(dwell,1), cont; clear err_cnt, pass, first_fail; vec_idx=0; load dwell counter with D; go HOLD.
REQ-020 mode, dwell SHALL NOT affect a sweep after latching; cont SHALL be resampled at each DONE.
REQ-021 {a_out,b_out} SHALL equal vec_idx in HOLD; vector order 00, 01, 10, 11.
REQ-022 Each vector SHALL be driven for exactly D cycles; counter decrements once per cycle in HOLD.
REQ-023 c_in SHALL be sampled only on the edge ending the D-th cycle of each vector, compared to f(mode,a_out,b_out).
REQ-024 Mismatch: err_cnt += 1, saturating at 2^ERR_W-1; first_fail set to {1,vec_idx} only if valid bit is 0.
REQ-025 Last cycle of vector 3 -> go DONE; otherwise vec_idx+1, reload counter with D.
REQ-026 DONE lasts exactly one cycle: done=1, busy=0, a_out=b_out=0; pass=1 if err_cnt==0 including final sample.
REQ-027 From DONE: if cont=1 -> go HOLD at vec_idx=0 with same latched mode/D, err_cnt and first_fail NOT cleared; else go IDLE.
REQ-028 Latency: start at edge E0 -> busy high cycles 1..4D, done high cycle 4D+1, back in IDLE cycle 4D+2 (cont=0).
REQ-029 busy SHALL be high only in HOLD; start while busy or in DONE SHALL be ignored.
REQ-030 pass and err_cnt SHALL hold their value in IDLE until the next accepted start.
REQ-031 In IDLE: a_out=b_out=0, vec_idx=0, busy=0, done=0.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, a_out=b_out=0, vec_idx=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=000, dwell counter 0.
REQ-033 rst asserted mid-sweep SHALL abort with no done pulse; first start after release begins a fresh sweep at vector 00.

Verification
REQ-034 mode=00, dwell=3, correct AND DUT, start pulse -> a/b 00,01,10,11 each 3 cycles, done in cycle 13, pass=1, err_cnt=0.
REQ-035 mode=01 (OR) against AND DUT, dwell=1 -> mismatches at vectors 1,2; err_cnt=2, first_fail=101, pass=0, done in cycle 5.
REQ-036 dwell=0 -> identical timing to dwell=1; start reasserted while busy -> no restart, done pulse exactly once.
REQ-037 cont=1, mode=11 against AND DUT for 3 sweeps -> err_cnt=12, first_fail=100, done pulses every 4D+1 cycles; drop cont -> IDLE after next done.
REQ-038 ERR_W=2, cont=1, always-wrong DUT -> err_cnt saturates at 3, no wrap.
REQ-039 rst pulse during vector 2 -> all outputs to reset values asynchronously, no done; next start restarts at 00 with err_cnt=0.

Source files
------------

// File: rtl/gate_vector_seq_if.sv
// gate_vector_seq_if
// Bundles the control, stimulus/response and status signals of the two-input
// gate test sequencer.
//
// Signals:
//   start, cont, mode, dwell  : sweep control (driven by the master)
//   c_in                      : response of the gate under test (master -> slave)
//   a_out, b_out              : registered stimulus to the gate under test
//   busy, done, pass          : sweep status
//   err_cnt, first_fail       : mismatch bookkeeping since the last start
//   vec_idx                   : vector currently applied
//   dbg_state                 : current FSM state (0 IDLE, 1 HOLD, 2 DONE)
//
// Handshake: start is a level sampled on every rising edge; it is accepted
// only while the sequencer is idle (busy=0 and done=0) and ignored otherwise,
// so there is no separate ready signal. done is a single-cycle pulse.
interface gate_vector_seq_if #(
    parameter int DWELL_W = 8,
    parameter int ERR_W   = 8
);
    logic               start;
    logic               cont;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic               c_in;
    logic               a_out;
    logic               b_out;
    logic               busy;
    logic               done;
    logic               pass;
    logic [ERR_W-1:0]   err_cnt;
    logic [2:0]         first_fail;
    logic [1:0]         vec_idx;
    logic [1:0]         dbg_state;

    modport master (
        output start, cont, mode, dwell, c_in,
        input  a_out, b_out, busy, done, pass, err_cnt, first_fail, vec_idx,
               dbg_state
    );

    modport slave (
        input  start, cont, mode, dwell, c_in,
        output a_out, b_out, busy, done, pass, err_cnt, first_fail, vec_idx,
               dbg_state
    );
endinterface

// File: rtl/gate_vector_seq.sv
// gate_vector_seq
// Applies the four input vectors 00, 01, 10, 11 to an external two-input gate,
// holds each for D cycles, samples the gate response at the end of each vector
// and compares it against the selected gate function (AND, OR, XOR, NAND).
// Mismatches are counted (saturating) and the first failing vector recorded.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : gate_vector_seq_if.slave (control, stimulus, response, status)
module gate_vector_seq #(
    parameter int DWELL_W = 8,
    parameter int ERR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    gate_vector_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [2:0]         ff_q, ff_d;
    logic               pass_q, pass_d;
    logic               a_q, a_d;
    logic               b_q, b_d;

    logic               exp_c;
    logic               last_cycle;
    logic               mismatch;
    logic [DWELL_W-1:0] dwell_eff;

    // Expected gate output for the vector currently on a_out/b_out.
    always_comb begin
        exp_c = 1'b0;
        case (mode_q)
            2'b00:   exp_c = a_q & b_q;
            2'b01:   exp_c = a_q | b_q;
            2'b10:   exp_c = a_q ^ b_q;
            default: exp_c = ~(a_q & b_q);
        endcase
    end

    // A dwell of zero behaves exactly like a dwell of one.
    assign dwell_eff  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    // The counter holds the number of cycles left on the current vector,
    // including the present one, so a value of 1 marks the sampling cycle.
    assign last_cycle = (cnt_q <= DWELL_W'(1));
    assign mismatch   = (state_q == S_HOLD) && last_cycle && (bus.c_in != exp_c);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        a_d     = 1'b0;
        b_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = 2'd0;
                if (bus.start) begin
                    mode_d  = bus.mode;
                    dwell_d = dwell_eff;
                    cnt_d   = dwell_eff;
                    err_d   = '0;
                    ff_d    = 3'b000;
                    pass_d  = 1'b0;
                    idx_d   = 2'd0;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                cnt_d = cnt_q - DWELL_W'(1);
                if (mismatch) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!ff_q[2]) begin
                        ff_d = {1'b1, idx_q};
                    end
                end
                if (last_cycle) begin
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                        idx_d   = 2'd0;
                        cnt_d   = '0;
                        // err_d already includes the final sample.
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = dwell_q;
                    end
                end
            end

            S_DONE: begin
                idx_d = 2'd0;
                // Continuous mode is decided from the live cont input here, so
                // dropping cont mid-sweep ends the run after the current sweep.
                if (bus.cont) begin
                    state_d = S_HOLD;
                    cnt_d   = dwell_q;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase

        // Stimulus registers track the vector index only while holding.
        if (state_d == S_HOLD) begin
            a_d = idx_d[1];
            b_d = idx_d[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            dwell_q <= '0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            err_q   <= '0;
            ff_q    <= 3'b000;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.busy       = (state_q == S_HOLD);
    assign bus.done       = (state_q == S_DONE);
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.first_fail = ff_q;
    assign bus.vec_idx    = idx_q;
    assign bus.dbg_state  = state_q;

endmodule
